// File: rtl/test_value_uart_tx.sv
// test_value_uart_tx: watches a memory-mapped test word and sends every new value
// as DATA_WIDTH/8 back-to-back 8N1 bytes, most-significant byte first, LSB-first bits.
module test_value_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] TestValue,
    output logic                  TxLine,
    output logic                  Busy,
    output logic                  Pending,
    output logic [CNT_WIDTH-1:0]  FrameCount,
    output logic [CNT_WIDTH-1:0]  DropCount
);
    localparam int NUM_BYTES  = DATA_WIDTH / 8;
    localparam int BIT_CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [BIT_CNT_W-1:0]  BIT_CNT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_IDX_W-1:0] BYTE_IDX_LAST = BYTE_IDX_W'(NUM_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]            r_state;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [2:0]            r_bit_idx;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [DATA_WIDTH-1:0] r_shift_word;
    logic [DATA_WIDTH-1:0] r_last_value;
    logic [DATA_WIDTH-1:0] r_pending_value;
    logic                  r_pending;
    logic                  r_tx;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_frame_count;
    logic [CNT_WIDTH-1:0]  r_drop_count;

    logic [7:0]            w_cur_byte;
    logic [2:0]            w_next_bit_idx;
    logic                  w_bit_done;
    logic [DATA_WIDTH-1:0] w_change_ref;
    logic                  w_busy_change;
    logic                  w_load_pending;
    logic                  w_load_live;
    logic [DATA_WIDTH-1:0] w_load_value;

    // The word shifts left by a byte after each stop bit, so the byte on air is always the top one.
    assign w_cur_byte     = r_shift_word[DATA_WIDTH-1 -: 8];
    assign w_next_bit_idx = r_bit_idx + 3'd1;
    assign w_bit_done     = (r_bit_cnt == BIT_CNT_LAST);

    assign w_change_ref   = r_pending ? r_pending_value : r_last_value;
    assign w_busy_change  = r_busy && (TestValue != w_change_ref);
    assign w_load_pending = (r_state == S_IDLE) && r_pending;
    assign w_load_live    = (r_state == S_IDLE) && !r_pending && (TestValue != r_last_value);
    assign w_load_value   = r_pending ? r_pending_value : TestValue;

    // Pending buffer and drop counter; the buffer empties on the edge the FSM loads from it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending       <= 1'b0;
            r_pending_value <= '0;
            r_drop_count    <= '0;
        end else if (w_busy_change) begin
            r_pending       <= 1'b1;
            r_pending_value <= TestValue;
            if (r_pending && (r_drop_count != '1))
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
        end else if (w_load_pending) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the word buffers are reset too, so a reset mid-frame leaves nothing stale to resend.
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_bit_idx     <= '0;
            r_byte_idx    <= '0;
            r_shift_word  <= '0;
            r_last_value  <= '0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_pending || w_load_live) begin
                        r_shift_word <= w_load_value;
                        r_last_value <= w_load_value;
                        r_state      <= S_START;
                        r_tx         <= 1'b0;
                        r_busy       <= 1'b1;
                        r_byte_idx   <= '0;
                        r_bit_cnt    <= '0;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= w_next_bit_idx;
                            r_tx      <= w_cur_byte[w_next_bit_idx];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        if (r_byte_idx == BYTE_IDX_LAST) begin
                            r_state       <= S_IDLE;
                            r_busy        <= 1'b0;
                            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
                        end else begin
                            r_byte_idx   <= r_byte_idx + BYTE_IDX_W'(1);
                            r_shift_word <= r_shift_word << 8;
                            r_tx         <= 1'b0;
                            r_state      <= S_START;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign TxLine     = r_tx;
    assign Busy       = r_busy;
    assign Pending    = r_pending;
    assign FrameCount = r_frame_count;
    assign DropCount  = r_drop_count;

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Randomised bench for test_value_uart_tx: a timing-based reference model predicts the
// serial line and counters every cycle, plus directed frame decodes for the key scenarios.
module tb_test_value_uart_tx;
    localparam int CPB          = 4;
    localparam int NB           = 4;
    localparam int BIT_SLOTS    = 10 * CPB;
    localparam int FRAME_CYCLES = NB * BIT_SLOTS;

    logic        CLK;
    logic        RST;
    logic [31:0] TestValue;
    logic        TxLine;
    logic        Busy;
    logic        Pending;
    logic [7:0]  FrameCount;
    logic [7:0]  DropCount;

    int checks   = 0;
    int failures = 0;

    test_value_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (32),
        .CNT_WIDTH   (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .TestValue (TestValue),
        .TxLine    (TxLine),
        .Busy      (Busy),
        .Pending   (Pending),
        .FrameCount(FrameCount),
        .DropCount (DropCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame position is elapsed cycles since the load edge.
    bit          m_valid = 0;
    int unsigned m_cycle = 0;
    bit          m_busy  = 0;
    int unsigned m_start = 0;
    logic [31:0] m_word  = '0;
    logic [31:0] m_last  = '0;
    bit          m_pend  = 0;
    logic [31:0] m_pend_val = '0;
    int unsigned m_frames_total = 0;
    int unsigned m_drops = 0;
    bit          wrap_seen = 0;

    task automatic model_start(input logic [31:0] v);
        m_busy  = 1;
        m_start = m_cycle;
        m_word  = v;
        m_last  = v;
    endtask

    always @(posedge CLK) begin
        logic [31:0] ref_v;
        m_cycle++;
        if (RST) begin
            m_valid = 1;
            m_busy  = 0;
            m_pend  = 0;
            m_last  = '0;
            m_frames_total = 0;
            m_drops = 0;
            wrap_seen = 0;
        end else if (m_busy) begin
            ref_v = m_pend ? m_pend_val : m_last;
            if (TestValue != ref_v) begin
                if (m_pend) m_drops++;
                m_pend     = 1;
                m_pend_val = TestValue;
            end
            if (m_cycle - m_start == FRAME_CYCLES) begin
                m_busy = 0;
                m_frames_total++;
            end
        end else if (m_pend) begin
            model_start(m_pend_val);
            m_pend = 0;
        end else if (TestValue != m_last) begin
            model_start(TestValue);
        end
    end

    function automatic logic exp_tx();
        int k, b, slot;
        logic [31:0] byte_v;
        if (!m_busy) return 1'b1;
        k    = int'(m_cycle - m_start);
        b    = k / BIT_SLOTS;
        slot = (k % BIT_SLOTS) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        byte_v = (m_word >> (8 * (NB - 1 - b))) & 32'hFF;
        return byte_v[slot-1];
    endfunction

    always @(negedge CLK) begin
        logic [7:0] f8;
        if (m_valid) begin
            f8 = m_frames_total[7:0];
            check("tx",      {31'd0, TxLine},  {31'd0, exp_tx()});
            check("busy",    {31'd0, Busy},    {31'd0, m_busy});
            check("pending", {31'd0, Pending}, {31'd0, m_pend});
            check("frames",  {24'd0, FrameCount}, {24'd0, f8});
            check("drops",   {24'd0, DropCount}, (m_drops > 255) ? 32'd255 : m_drops);
            if (m_frames_total == 256 && !wrap_seen) begin
                wrap_seen = 1;
                check("frame_wrap", {24'd0, FrameCount}, 32'd0);
            end
        end
    end

    // Waits (bounded) for the start bit; returns cycles waited.
    task automatic wait_start(output int waited);
        waited = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (TxLine === 1'b0) begin
                waited = i;
                break;
            end
        end
        check("start_seen", {31'd0, waited >= 0}, 32'd1);
    endtask

    // Called on the negedge where the start bit is first visible; samples mid-bit.
    task automatic decode_frame(output logic [31:0] word, output int busy_cycles);
        int slot;
        word = '0;
        busy_cycles = (Busy === 1'b1) ? 1 : 0;
        for (int k = 1; k < FRAME_CYCLES; k++) begin
            @(negedge CLK);
            if (Busy === 1'b1) busy_cycles++;
            slot = (k % BIT_SLOTS) / CPB;
            if ((k % CPB) == 2 && slot >= 1 && slot <= 8)
                word[8 * (NB - 1 - k / BIT_SLOTS) + (slot - 1)] = TxLine;
        end
        @(negedge CLK);
        check("busy_drop_at_end", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, busy_cnt, busy_seen;
        logic [31:0] word;

        RST = 1'b1;
        TestValue = '0;
        repeat (3) @(negedge CLK);
        check("rst_tx",    {31'd0, TxLine}, 32'd1);
        check("rst_busy",  {31'd0, Busy},   32'd0);
        check("rst_drops", {24'd0, DropCount}, 32'd0);
        RST = 1'b0;

        // Quiet line: no frame while the word holds at the reset value.
        busy_seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (Busy === 1'b1) busy_seen++;
        end
        check("idle_no_busy", busy_seen, 32'd0);
        check("idle_frames", {24'd0, FrameCount}, 32'd0);

        // First frame: latency, byte order, busy duration.
        repeat (10) @(negedge CLK);
        TestValue = 32'h1234_5678;
        wait_start(waited);
        check("latency", waited, 32'd0);
        decode_frame(word, busy_cnt);
        check("frame1_word", word, 32'h1234_5678);
        check("frame1_busy", busy_cnt, FRAME_CYCLES);
        check("frame1_count", {24'd0, FrameCount}, 32'd1);

        // Two changes inside a frame: newest one wins, one drop, back-to-back start.
        repeat (5) @(negedge CLK);
        TestValue = 32'h1111_1111;
        wait_start(waited);
        repeat (20) @(negedge CLK);
        TestValue = 32'hAAAA_0001;
        repeat (20) @(negedge CLK);
        TestValue = 32'hBBBB_0002;
        @(negedge CLK);
        check("pend_set", {31'd0, Pending}, 32'd1);
        check("pend_drop", {24'd0, DropCount}, 32'd1);
        repeat (FRAME_CYCLES - 41) @(negedge CLK);
        check("gap_busy", {31'd0, Busy}, 32'd0);
        check("gap_tx",   {31'd0, TxLine}, 32'd1);
        @(negedge CLK);
        check("restart_tx",   {31'd0, TxLine}, 32'd0);
        check("restart_busy", {31'd0, Busy}, 32'd1);
        decode_frame(word, busy_cnt);
        check("frame3_word", word, 32'hBBBB_0002);
        check("frame3_busy", busy_cnt, FRAME_CYCLES);
        check("frame3_count", {24'd0, FrameCount}, 32'd3);

        // Reset in the middle of a frame.
        repeat (5) @(negedge CLK);
        TestValue = 32'h5A5A_5A5A;
        wait_start(waited);
        repeat (50) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_tx",      {31'd0, TxLine}, 32'd1);
        check("abort_busy",    {31'd0, Busy}, 32'd0);
        check("abort_pending", {31'd0, Pending}, 32'd0);
        check("abort_frames",  {24'd0, FrameCount}, 32'd0);
        TestValue = 32'hC3C3_0F0F;
        @(negedge CLK);
        RST = 1'b0;
        wait_start(waited);
        decode_frame(word, busy_cnt);
        check("post_reset_word", word, 32'hC3C3_0F0F);
        check("post_reset_busy", busy_cnt, FRAME_CYCLES);
        check("post_reset_count", {24'd0, FrameCount}, 32'd1);

        // Random traffic: frequent changes keep frames back-to-back and overflow the drop counter.
        for (int i = 0; i < 270 * (FRAME_CYCLES + 1); i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 7) == 0) TestValue = m_last;
                else TestValue = $urandom;
            end
        end
        repeat (2 * FRAME_CYCLES + 20) @(negedge CLK);
        check("drop_sat",   {24'd0, DropCount}, 32'h0000_00FF);
        check("drain_idle", {31'd0, Busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
